// File: rtl/bram_axis_m_intf_pkg.sv
// -----------------------------------------------------------------------------
// bram_axis_pkg
// Shared types and constants for the BRAM-to-AXIS master reader.
//   state_e     : controller FSM states (idle / streaming a run)
//   RD_LATENCY  : BRAM read latency in clock cycles
//   OBUF_DEPTH  : number of entries in the output buffer
// -----------------------------------------------------------------------------
package bram_axis_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam int RD_LATENCY = 1;
  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/bram_axis_m_fifo2.sv
// -----------------------------------------------------------------------------
// bram_axis_m_fifo2
// Two-entry FIFO holding {tlast, data} words returned by the BRAM.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and word
//   pop        : read request (advances the head)
//   head       : oldest stored word (all zeros after reset)
//   empty/full : occupancy flags
//   count      : number of stored words (0..2)
// A push while full is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module bram_axis_m_fifo2
  import bram_axis_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push_s;
  logic         do_pop_s;

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && (count_q != 2'd0);
    do_push_s = push && ((count_q != 2'(OBUF_DEPTH)) || do_pop_s);

    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'(OBUF_DEPTH));
  assign count = count_q;

endmodule

// File: rtl/bram_axis_m_intf.sv
// -----------------------------------------------------------------------------
// bram_axis_m_intf
// Reads a contiguous run of words from a BRAM port and emits them as an
// AXI4-Stream master, with tlast on the final word of the run.
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, synchronous active-low reset
//   start, start_addr, xfer_len      : run command (taken only when idle;
//                                      xfer_len == 0 is ignored)
//   busy, done                       : run in progress / one-cycle completion
//   bram_clk/addr/en/wen/rdata       : BRAM read port (1-cycle read latency)
//   m00_axis_t*                      : AXI4-Stream master
// Reads are issued only when the output buffer is guaranteed to have room
// for the returning word, which lets one beat per cycle flow with tready high
// while never overflowing the two-entry buffer.
// -----------------------------------------------------------------------------
module bram_axis_m_intf
  import bram_axis_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DEPTH             = 13
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic                                  start,
  input  logic [BRAM_DEPTH-1:0]                 start_addr,
  input  logic [BRAM_DEPTH:0]                   xfer_len,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  bram_clk,
  output logic [BRAM_DEPTH-1:0]                 bram_addr,
  output logic                                  bram_en,
  output logic                                  bram_wen,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     bram_rdata,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW = BRAM_DEPTH;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          done_q, done_d;

  logic          issue_s;
  logic [AW-1:0] rd_addr_s;
  logic          pop_s;
  logic          push_s;
  logic [2:0]    credit_s;
  logic [DW:0]   fifo_head_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic [1:0]    fifo_count_s;

  // Returned word is tagged with tlast when it was the final read of the run.
  bram_axis_m_fifo2 #(
    .W(DW + 1)
  ) u_obuf (
    .clk   (m00_axis_aclk),
    .rst_n (m00_axis_aresetn),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({inflight_last_q, bram_rdata}),
    .head  (fifo_head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  assign pop_s  = !fifo_empty_s && m00_axis_tready;
  assign push_s = inflight_q && (!fifo_full_s || pop_s);

  // Buffer occupancy after this edge: the read in flight lands now, the
  // handshaken beat leaves now. A new read lands one edge later.
  assign credit_s = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};

  // FSM next state, read issue and run bookkeeping.
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    len_d           = len_q;
    issued_d        = issued_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    issue_s         = 1'b0;
    rd_addr_s       = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && (xfer_len != '0)) begin
          state_d  = ST_STREAM;
          base_d   = start_addr;
          len_d    = xfer_len;
          issued_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        if ((issued_q < len_q) && (credit_s < 3'(OBUF_DEPTH))) begin
          issue_s         = 1'b1;
          // Address arithmetic wraps at the BRAM size.
          rd_addr_s       = base_q + issued_q[AW-1:0];
          issued_d        = issued_q + CNT_ONE;
          inflight_d      = 1'b1;
          inflight_last_d = (issued_q == (len_q - CNT_ONE));
        end else begin
          issue_s = 1'b0;
        end

        if (pop_s && fifo_head_s[DW]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_STREAM;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any run and drops the read in flight.
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  assign busy            = (state_q == ST_STREAM);
  assign done            = done_q;
  assign bram_clk        = m00_axis_aclk;
  assign bram_en         = issue_s;
  assign bram_addr       = rd_addr_s;
  assign bram_wen        = 1'b0;
  assign m00_axis_tvalid = !fifo_empty_s;
  assign m00_axis_tdata  = fifo_head_s[DW-1:0];
  // Gate the tag so a stale entry never shows tlast while the buffer is empty.
  assign m00_axis_tlast  = !fifo_empty_s && fifo_head_s[DW];
  assign m00_axis_tstrb  = {(DW/8){1'b1}};

endmodule

// File: tb/tb_bram_axis_m_intf.sv
// -----------------------------------------------------------------------------
// tb_bram_axis_m_intf
// Self-checking bench: a behavioural BRAM plus a queue-based model of the
// expected address and beat sequences, compared against the DUT each cycle,
// and literal expectations for latency, wrap and reset scenarios.
// -----------------------------------------------------------------------------
module tb_bram_axis_m_intf;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NW = 256;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic [AW:0]       xfer_len;
  logic              busy, done, bram_clk, bram_en, bram_wen;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_rdata = '0;
  logic              tvalid, tlast, tready;
  logic [DW-1:0]     tdata;
  logic [DW/8-1:0]   tstrb;

  bram_axis_m_intf #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .BRAM_DEPTH(AW)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(aresetn),
    .start           (start),
    .start_addr      (start_addr),
    .xfer_len        (xfer_len),
    .busy            (busy),
    .done            (done),
    .bram_clk        (bram_clk),
    .bram_addr       (bram_addr),
    .bram_en         (bram_en),
    .bram_wen        (bram_wen),
    .bram_rdata      (bram_rdata),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [NW];
  initial for (int i = 0; i < NW; i++) mem[i] = 32'hA000_0000 + 32'(i);

  always @(posedge bram_clk) if (bram_en) bram_rdata <= mem[bram_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- model state (written only by the monitor) -------------
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic          busy_m = 1'b0;
  logic          done_m = 1'b0;
  int            issued_m = 0;
  int            popped_m = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          chk_en = 1'b0;

  // ---------------- logs read by the directed tests -----------------------
  logic [AW-1:0] addr_log [$];
  logic [DW-1:0] beat_data [$];
  logic          beat_last [$];
  int            beat_cyc [$];
  int            first_valid_cyc = -1;
  int            done_cyc = -1;
  int            en_cnt = 0;

  // Per-cycle compare of DUT outputs against the model, then model update.
  always @(negedge clk) begin
    if (chk_en) begin
      logic hs, lastp;
      hs = tvalid && tready;
      lastp = 1'b0;
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      if (done) done_cyc = cyc;
      if (bram_en) begin
        en_cnt++;
        issued_m++;
        addr_log.push_back(bram_addr);
        if (exp_addr.size() == 0) chk("spurious_bram_en", bram_en, 1'b0);
        else chk("bram_addr", bram_addr, exp_addr.pop_front());
      end
      if (tvalid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_data.size() == 0) chk("spurious_tvalid", tvalid, 1'b0);
        else begin
          chk("tdata", tdata, exp_data[0]);
          chk("tlast", tlast, exp_last[0]);
        end
        if (stall_prev) begin
          chk("hold_tdata", tdata, prev_data);
          chk("hold_tlast", tlast, prev_last);
        end
      end else if (stall_prev) begin
        chk("hold_tvalid", tvalid, 1'b1);
      end
      if (hs && exp_data.size() != 0) begin
        lastp = exp_last.pop_front();
        void'(exp_data.pop_front());
        popped_m++;
        beat_data.push_back(tdata);
        beat_last.push_back(tlast);
        beat_cyc.push_back(cyc);
      end
      if (bram_en) chk("outstanding_le2", 64'((issued_m - popped_m) <= 2), 64'd1);
      stall_prev = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;

      if (!aresetn) begin
        busy_m = 1'b0; done_m = 1'b0; stall_prev = 1'b0;
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
        issued_m = 0; popped_m = 0;
      end else begin
        done_m = hs && lastp;
        if (busy_m) begin
          if (hs && lastp) busy_m = 1'b0;
        end else if (start && xfer_len != '0) begin
          busy_m = 1'b1; issued_m = 0; popped_m = 0;
          for (int i = 0; i < int'(xfer_len); i++) begin
            logic [AW-1:0] a;
            a = start_addr + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
            exp_last.push_back(i == int'(xfer_len) - 1);
          end
        end
      end
    end
  end

  // ---------------- tready pattern generator ------------------------------
  int rmode = 0;
  int rcnt  = 0;
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      case (rmode)
        1:       tready = ~tready;
        2:       tready = (rcnt % 3 == 0);
        default: tready = 1'b1;
      endcase
    end
  end

  int start_cyc = 0;

  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; xfer_len = l;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_m || exp_data.size() != 0) && n < budget) begin
      @(posedge clk); n++;
    end
    chk("run_complete", {63'd0, busy_m || (exp_data.size() != 0)}, 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic clr_logs();
    addr_log.delete(); beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    first_valid_cyc = -1; done_cyc = -1;
  endtask

  initial begin
    int n, e0;
    aresetn = 1'b0; start = 1'b0; start_addr = '0; xfer_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_bram_addr", bram_addr, 8'd0);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 32'd0);
    chk("tstrb", tstrb, 4'hF);
    chk("bram_wen", bram_wen, 1'b0);
    chk_en = 1'b1;
    @(posedge clk); #1 aresetn = 1'b1;

    // 1: basic run, tready high, latency and throughput.
    rmode = 0; clr_logs();
    do_start(8'd0, 9'd4);
    wait_idle(50);
    chk("t1_nbeats", beat_data.size(), 4);
    if (beat_data.size() == 4) begin
      chk("t1_d0", beat_data[0], 32'hA000_0000);
      chk("t1_d1", beat_data[1], 32'hA000_0001);
      chk("t1_d2", beat_data[2], 32'hA000_0002);
      chk("t1_d3", beat_data[3], 32'hA000_0003);
      chk("t1_last", {beat_last[3], beat_last[2], beat_last[1], beat_last[0]}, 4'b1000);
      chk("t1_consec", beat_cyc[3] - beat_cyc[0], 3);
      chk("t1_done_cyc", done_cyc, beat_cyc[3] + 1);
    end
    chk("t1_latency", first_valid_cyc - start_cyc, 2);

    // 2: alternating tready, 8 beats.
    rmode = 1; clr_logs();
    do_start(8'd40, 9'd8);
    wait_idle(100);
    chk("t2_nbeats", beat_data.size(), 8);
    if (beat_data.size() == 8) chk("t2_d7", beat_data[7], 32'hA000_002F);

    // 3: sparse tready.
    rmode = 2; clr_logs();
    do_start(8'd60, 9'd7);
    wait_idle(100);
    chk("t3_nbeats", beat_data.size(), 7);

    // 4: address wrap 254,255,0,1.
    rmode = 0; clr_logs();
    do_start(8'd254, 9'd4);
    wait_idle(50);
    chk("t4_naddr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t4_a0", addr_log[0], 8'd254);
      chk("t4_a1", addr_log[1], 8'd255);
      chk("t4_a2", addr_log[2], 8'd0);
      chk("t4_a3", addr_log[3], 8'd1);
    end
    if (beat_data.size() == 4) begin
      chk("t4_d0", beat_data[0], 32'hA000_00FE);
      chk("t4_d2", beat_data[2], 32'hA000_0000);
    end

    // 5: single-word run.
    clr_logs();
    do_start(8'd7, 9'd1);
    wait_idle(30);
    chk("t5_nbeats", beat_data.size(), 1);
    if (beat_data.size() == 1) begin
      chk("t5_d0", beat_data[0], 32'hA000_0007);
      chk("t5_last", beat_last[0], 1'b1);
    end

    // 6: zero length is ignored.
    clr_logs(); e0 = en_cnt;
    do_start(8'd3, 9'd0);
    repeat (6) @(posedge clk);
    chk("t6_no_en", en_cnt - e0, 0);
    chk("t6_no_done", done_cyc, -1);

    // 7: start during STREAM is ignored.
    rmode = 1; clr_logs();
    do_start(8'd10, 9'd6);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'd200; xfer_len = 9'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(100);
    chk("t7_nbeats", beat_data.size(), 6);
    if (beat_data.size() == 6) chk("t7_d5", beat_data[5], 32'hA000_000F);

    // 8: full-size run of 256 words.
    rmode = 0; clr_logs();
    do_start(8'd5, 9'd256);
    wait_idle(400);
    chk("t8_nbeats", beat_data.size(), 256);
    if (beat_data.size() == 256) begin
      chk("t8_dlast", beat_data[255], 32'hA000_0004);
      chk("t8_last_only_end", {beat_last[254], beat_last[255]}, 2'b01);
    end

    // 9: reset after 3 beats, then a clean run from 100.
    clr_logs();
    do_start(8'd20, 9'd8);
    n = 0;
    while (popped_m < 3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t9_reached3", 64'(popped_m >= 3), 64'd1);
    aresetn = 1'b0;
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    chk("t9_tvalid", tvalid, 1'b0);
    chk("t9_busy", busy, 1'b0);
    chk("t9_bram_en", bram_en, 1'b0);
    repeat (2) @(posedge clk);
    clr_logs();
    do_start(8'd100, 9'd2);
    wait_idle(30);
    chk("t9_nbeats", beat_data.size(), 2);
    if (beat_data.size() == 2) begin
      chk("t9_d0", beat_data[0], 32'hA000_0064);
      chk("t9_d1", beat_data[1], 32'hA000_0065);
      chk("t9_last", {beat_last[1], beat_last[0]}, 2'b10);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_axis_m_intf.md
Name: bram_axis_m_intf

Overview:
- Reader/transmitter counterpart of the AXIS-to-BRAM slave interface: on a start command it reads a contiguous run of words from a BRAM port and emits them as an AXI4-Stream master.
- Handles 1-cycle BRAM read latency and downstream backpressure with a 2-entry output buffer and credit-limited read issue.
- Sustains one beat per cycle when tready is held high.
- Asserts tlast on the final word of each run.

Parameters:
- C_M00_AXIS_TDATA_WIDTH, 32, stream and BRAM data width in bits; must be a multiple of 8.
- BRAM_DEPTH, 13, BRAM address width in bits; a run holds up to 2^BRAM_DEPTH words.

Ports:
- m00_axis_aclk  in  1  single clock for all logic; also drives bram_clk.
- m00_axis_aresetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle command pulse; sampled only when idle.
- start_addr  in  BRAM_DEPTH  first BRAM word address; sampled with start.
- xfer_len  in  BRAM_DEPTH+1  number of words; 0 means the command is ignored.
- busy  out  1  high from the accepted start until the last beat handshakes.
- done  out  1  one-cycle pulse in the cycle after the last-beat handshake.
- bram_clk  out  1  equals m00_axis_aclk.
- bram_addr  out  BRAM_DEPTH  read address.
- bram_en  out  1  read enable; high only on cycles that issue a read.
- bram_wen  out  1  constant 0.
- bram_rdata  in  C_M00_AXIS_TDATA_WIDTH  read data, valid 1 cycle after bram_en.
- m00_axis_tvalid  out  1  AXIS valid.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  AXIS data.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all ones.
- m00_axis_tlast  out  1  high on the final beat of a run.
- m00_axis_tready  in  1  AXIS ready.

Behaviour:
- Reset values: busy=0, done=0, bram_en=0, bram_addr=0, tvalid=0, tlast=0, tdata=0. Buffer is emptied; any in-flight read is discarded.
- Reset mid-run aborts the run entirely. Outputs take their reset values at the next edge.
- FSM states:
  - IDLE: start && xfer_len!=0 -> STREAM. Latch start_addr and xfer_len; clear issue and beat counters; busy=1.
  - STREAM: issue reads and emit beats. When the beat with tlast handshakes (tvalid && tready) -> IDLE, with busy=0 and done=1 for one cycle.
- start in STREAM is ignored. start with xfer_len=0 in IDLE is ignored: no bram_en, no done.
- Read issue rule:
  - issue when issued_cnt < len && (occupancy + inflight - pop) < 2.
  - pop = tvalid && tready this cycle; inflight = bram_en registered one cycle.
  - On each issue: bram_en=1, bram_addr = latched start_addr + issued_cnt, modulo 2^BRAM_DEPTH (wraps).
- Read data is pushed into the 2-entry FIFO in the cycle after bram_en. Overflow is impossible by the credit rule; the bench asserts this.
- tvalid = FIFO not empty. tdata is the FIFO head, and tlast is the head tag. The tag is set on the push of word index len-1.
- AXIS rules: once tvalid rises, tvalid, tdata and tlast hold until the handshake. tvalid never depends on tready.
- Latency: start sampled at edge E0 -> bram_en/addr high after E0 -> data pushed at E2 -> first tvalid after E2. That is 2 cycles from the start edge to the first tvalid; with tready=1, steady state is 1 beat per cycle.
- Counters are BRAM_DEPTH+1 bits so xfer_len = 2^BRAM_DEPTH is legal.
- Simultaneous push and pop in the same cycle keeps occupancy unchanged. The last pop and done/IDLE may coincide with no extra cycle.

Decomposition:
- Package bram_axis_pkg holds:
  - the FSM state enum (IDLE, STREAM);
  - localparam RD_LATENCY=1;
  - localparam OBUF_DEPTH=2.
- One sub-module, bram_axis_m_fifo2: a 2-entry FIFO of {tlast, data} with push, pop, head, empty, full and count outputs.

Test Plan:
- BRAM mem[i]=0xA000_0000+i, start_addr=0, xfer_len=4, tready=1 -> tdata A0000000..A0000003 on 4 consecutive cycles. First tvalid 2 cycles after the start edge; tlast only on the 4th beat; done pulse 1 cycle after.
- xfer_len=8, tready pattern 1,0,1,0,... -> 8 beats in order with no loss or duplication. tdata/tlast are stable during stalls; FIFO never overflows (assertion); at most 2 reads outstanding.
- BRAM_DEPTH=4, start_addr=14, xfer_len=4 -> bram_addr sequence 14,15,0,1; data mem[14],mem[15],mem[0],mem[1].
- xfer_len=1 -> a single beat with tlast=1. Separately, xfer_len=0 -> no bram_en, busy stays 0, no done.
- start pulsed again during STREAM with a different start_addr -> ignored; the original run completes unchanged.
- aresetn low for 1 cycle after 3 of 8 beats -> next cycle tvalid=0, busy=0, bram_en=0. A new start with start_addr=100, xfer_len=2 then yields mem[100], mem[101] with no stale data.
